cla_nl_pipe_reg: RTL and testbench
==================================

# cla_nl_pipe_reg

Pipeline register stage between the CLA nonlinear part (`gen_nonlinear_part`) and the linear part of the decomposed adder. It captures each operand pair `a`, `b` together with the NNL-bit nonlinear vector computed from it, and presents all three to the downstream linear part under a valid/ready handshake. A two-entry skid buffer keeps one transfer per cycle while `in_ready` stays a registered signal. A wrapping transfer counter supports bench checking.

## Interface
- NBIT, 4, operand width; shared from `constants.v`.
- NNL, 56, width of the nonlinear vector; shared from `constants.v`.
- CNTW, 8, width of the transfer counter.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a valid {in_a, in_b, in_n}.
- in_ready  output  1  stage can accept; driven directly from a register.
- in_a  input  NBIT  operand a.
- in_b  input  NBIT  operand b.
- in_n  input  NNL  nonlinear vector for (in_a, in_b).
- out_valid  output  1  {out_a, out_b, out_n} is valid.
- out_ready  input  1  downstream linear part accepts.
- out_a  output  NBIT  registered operand a.
- out_b  output  NBIT  registered operand b.
- out_n  output  NNL  registered nonlinear vector.
- level  output  2  occupancy: 0, 1 or 2.
- xfer_cnt  output  CNTW  count of completed output transfers, modulo 2^CNTW.

## Operation
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Storage: main register M, which drives the out_* ports, and skid register S. Each stores {a, b, n} as one word; fields are never mixed between entries.
- States: EMPTY (level 0), ONE (M full), TWO (M and S full).
- EMPTY:
  - in_fire: M <= in, go to ONE.
  - otherwise: stay in EMPTY.
- ONE:
  - in_fire & out_fire: M <= in, stay in ONE.
  - in_fire only: S <= in, go to TWO.
  - out_fire only: go to EMPTY.
  - neither: hold.
- TWO:
  - in_ready = 0, so in_fire cannot occur.
  - out_fire: M <= S, go to ONE.
  - otherwise: hold.
- out_valid = (state != EMPTY). in_ready = (state != TWO) and not in reset.
- Data is passed through unmodified, including operand pairs whose sum overflows NBIT. No arithmetic is performed on a, b or n.
- xfer_cnt increments by 1 on every out_fire and wraps from 2^CNTW-1 to 0.
- Strict FIFO ordering: outputs appear in exactly the order they were accepted.
- out_* data must remain stable while out_valid=1 and out_ready=0.
- in_valid with in_ready=0 is ignored. Upstream is expected to hold its data, but this stage does not check that.

## Timing
- Reset, sampled on a rising edge with rst=1:
  - state = EMPTY, M = 0, S = 0.
  - out_valid = 0, out_a/out_b/out_n = 0.
  - level = 0, xfer_cnt = 0.
  - in_ready = 0 during every cycle in which rst=1; in_ready = 1 in the first cycle after rst falls.
- Reset mid-operation discards the contents of both M and S. No out_fire is counted in the reset cycle.
- Latency: an input accepted at edge k is visible on out_* with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one transfer per cycle while out_ready=1. No bubbles in the ONE state under simultaneous in_fire and out_fire.
- Backpressure: after out_ready drops, at most one further input is accepted (into S). in_ready then falls on the following edge.
- Combinational paths: none from out_ready to in_ready, and none from in_* to out_*.

## Test plan
- Reset and idle:
  - Stimulus: hold rst=1 for 2 cycles, then release.
  - Required: every output is 0 during reset; in_ready=1 on the first cycle after release; out_valid stays 0 while in_valid=0.
- Streaming:
  - Stimulus: out_ready=1; back-to-back inputs (a,b) = (0,0), (2,0), (2,3), (5,3), (5,10), (6,10), (6,1), each with a distinct n pattern.
  - Required: each triple appears exactly one cycle after acceptance, in the same order; xfer_cnt = 7 at the end; level never exceeds 1.
- Backpressure:
  - Stimulus: fill the stage with out_ready=0 while presenting inputs (5,10), (6,10), (6,1).
  - Required: level = 2; in_ready = 0; (6,1) is not accepted; out_* holds (5,10) stably.
  - Stimulus: raise out_ready for 3 cycles.
  - Required: (5,10), (6,10), (6,1) emerge in that order.
- Simultaneous events:
  - Stimulus: in state ONE, assert in_fire and out_fire together for 4 cycles.
  - Required: level stays at 1 and each new word appears on the next cycle.
- Counter wrap:
  - Stimulus: perform 257 output transfers with CNTW=8.
  - Required: xfer_cnt = 1.
- Reset mid-operation:
  - Stimulus: assert rst while level = 2.
  - Required: on the next cycle level = 0, out_valid = 0 and xfer_cnt = 0; after release, neither stored word is ever output.

Source files
------------

// File: rtl/cla_nl_pipe_reg.sv
// Pipeline register between the CLA nonlinear and linear parts: a two-entry skid
// buffer carrying {a, b, n} words under valid/ready, plus a wrapping transfer counter.
module cla_nl_pipe_reg #(
  parameter int NBIT = 4,
  parameter int NNL  = 56,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] in_a,
  input  logic [NBIT-1:0] in_b,
  input  logic [NNL-1:0]  in_n,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] out_a,
  output logic [NBIT-1:0] out_b,
  output logic [NNL-1:0]  out_n,
  output logic [1:0]      level,
  output logic [CNTW-1:0] xfer_cnt
);

  localparam int WW = 2*NBIT + NNL;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   m_q, m_d;
  logic [WW-1:0]   s_q, s_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic [WW-1:0]   in_word;
  logic            in_fire;
  logic            out_fire;

  assign in_word  = {in_a, in_b, in_n};
  // The ready flop resets high so the first post-reset cycle can accept; rst masks it while asserted.
  assign in_ready  = rdy_q & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign {out_a, out_b, out_n} = m_q;
  assign xfer_cnt  = cnt_q;

  always_comb begin
    level = 2'd0;
    case (state_q)
      EMPTY:   level = 2'd0;
      ONE:     level = 2'd1;
      TWO:     level = 2'd2;
      default: level = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    cnt_d   = cnt_q + {{(CNTW-1){1'b0}}, out_fire};
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          m_d     = in_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          m_d = in_word;
        end else if (in_fire) begin
          s_d     = in_word;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_cla_nl_pipe_reg.sv
// Self-checking bench for cla_nl_pipe_reg: scenario tasks with inline checks plus
// a scoreboard that records accepted words and matches them against output transfers.
module tb_cla_nl_pipe_reg;

  typedef struct packed {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [55:0] n;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic [55:0] in_n = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_a;
  logic [3:0]  out_b;
  logic [55:0] out_n;
  logic [1:0]  level;
  logic [7:0]  xfer_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t scoreboard[$];

  cla_nl_pipe_reg #(.NBIT(4), .NNL(56), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_n(out_n),
    .level(level), .xfer_cnt(xfer_cnt)
  );

  initial forever #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge the upcoming fires are already settled.
  always @(negedge clk) begin
    if (rst) begin
      scoreboard.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (scoreboard.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL sb_unexpected: got a=%0d b=%0d n=%h, want no output", out_a, out_b, out_n);
        end else begin
          word_t w;
          w = scoreboard.pop_front();
          if (out_a !== w.a || out_b !== w.b || out_n !== w.n) begin
            n_fail++;
            $display("[TB] FAIL sb_order: got a=%0d b=%0d n=%h, want a=%0d b=%0d n=%h",
                     out_a, out_b, out_n, w.a, w.b, w.n);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1)
        scoreboard.push_back('{a: in_a, b: in_b, n: in_n});
    end
  end

  function automatic logic [55:0] make_n(input int seed);
    return {24'(seed * 131 + 17), 32'hA5A5_3C3C ^ 32'(seed * 7919)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] a, input logic [3:0] b, input logic [55:0] n);
    in_a = a;
    in_b = b;
    in_n = n;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_a !== 4'd0 || out_b !== 4'd0 || out_n !== 56'd0 ||
          level !== 2'd0 || xfer_cnt !== 8'd0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: got v=%b a=%0d b=%0d n=%h lvl=%0d cnt=%0d rdy=%b, want all 0",
                 out_valid, out_a, out_b, out_n, level, xfer_cnt, in_ready);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: got %b, want 1", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL idle_valid: got %b, want 0", out_valid);
      end
    end
  endtask

  task automatic test_streaming();
    logic [3:0] ta[7];
    logic [3:0] tb[7];
    logic [55:0] n;
    ta = '{4'd0, 4'd2, 4'd2, 4'd5, 4'd5, 4'd6, 4'd6};
    tb = '{4'd0, 4'd0, 4'd3, 4'd3, 4'd10, 4'd10, 4'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n = make_n(i);
      present(ta[i], tb[i], n);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_a !== ta[i] || out_b !== tb[i] || out_n !== n || level > 2'd1) begin
        n_fail++;
        $display("[TB] FAIL stream_%0d: got v=%b a=%0d b=%0d n=%h lvl=%0d, want v=1 a=%0d b=%0d n=%h lvl<=1",
                 i, out_valid, out_a, out_b, out_n, level, ta[i], tb[i], n);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (xfer_cnt !== 8'd7 || level !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL stream_count: got cnt=%0d lvl=%0d, want cnt=7 lvl=0", xfer_cnt, level);
    end
  endtask

  task automatic test_backpressure();
    logic [55:0] n0, n1, n2;
    n0 = make_n(100);
    n1 = make_n(101);
    n2 = make_n(102);
    out_ready = 1'b0;
    present(4'd5, 4'd10, n0);
    tick();
    present(4'd6, 4'd10, n1);
    tick();
    present(4'd6, 4'd1, n2);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (level !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_a !== 4'd5 || out_b !== 4'd10 || out_n !== n0) begin
        n_fail++;
        $display("[TB] FAIL bp_full_%0d: got lvl=%0d rdy=%b v=%b a=%0d b=%0d n=%h, want lvl=2 rdy=0 v=1 a=5 b=10 n=%h",
                 c, level, in_ready, out_valid, out_a, out_b, out_n, n0);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_a !== 4'd6 || out_b !== 4'd10 || out_n !== n1 || level !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL bp_drain_1: got v=%b a=%0d b=%0d n=%h lvl=%0d, want v=1 a=6 b=10 n=%h lvl=1",
               out_valid, out_a, out_b, out_n, level, n1);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_a !== 4'd6 || out_b !== 4'd1 || out_n !== n2) begin
      n_fail++;
      $display("[TB] FAIL bp_drain_2: got v=%b a=%0d b=%0d n=%h, want v=1 a=6 b=1 n=%h",
               out_valid, out_a, out_b, out_n, n2);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || level !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL bp_drain_3: got v=%b lvl=%0d, want v=0 lvl=0", out_valid, level);
    end
  endtask

  task automatic test_simultaneous();
    logic [55:0] n;
    out_ready = 1'b0;
    present(4'd9, 4'd9, make_n(200));
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n = make_n(200 + i);
      present(4'(i), 4'(15 - i), n);
      tick();
      n_checks++;
      if (level !== 2'd1 || out_a !== 4'(i) || out_b !== 4'(15 - i) || out_n !== n) begin
        n_fail++;
        $display("[TB] FAIL simul_%0d: got lvl=%0d a=%0d b=%0d n=%h, want lvl=1 a=%0d b=%0d n=%h",
                 i, level, out_a, out_b, out_n, i, 15 - i, n);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      present(4'(i), 4'(i >> 4), make_n(300 + i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (xfer_cnt !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL counter_wrap: got %0d, want 1", xfer_cnt);
    end
  endtask

  task automatic test_reset_midop();
    logic [55:0] n;
    out_ready = 1'b0;
    present(4'd3, 4'd4, make_n(900));
    tick();
    present(4'd7, 4'd8, make_n(901));
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (level !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL midop_fill: got lvl=%0d, want 2", level);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (level !== 2'd0 || out_valid !== 1'b0 || xfer_cnt !== 8'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midop_reset: got lvl=%0d v=%b cnt=%0d rdy=%b, want 0 0 0 0",
               level, out_valid, xfer_cnt, in_ready);
    end
    rst = 1'b0;
    n = make_n(950);
    present(4'd15, 4'd15, n);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_a !== 4'd15 || out_b !== 4'd15 || out_n !== n) begin
      n_fail++;
      $display("[TB] FAIL midop_after: got v=%b a=%0d b=%0d n=%h, want v=1 a=15 b=15 n=%h",
               out_valid, out_a, out_b, out_n, n);
    end
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || xfer_cnt !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL midop_drain: got v=%b cnt=%0d, want v=0 cnt=1", out_valid, xfer_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_counter_wrap();
    test_reset_midop();
    n_checks++;
    if (scoreboard.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_leftover: got %0d pending words, want 0", scoreboard.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
